// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode/state types and the accumulator ALU
// shared by the multi-cycle CPU core and its PC unit.
package cpu_pkg;

  localparam int OPC_W = 3;
  localparam int ALU_W = 64;

  typedef enum logic [OPC_W-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    HALT   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    READ   = 3'd3,
    WRITE  = 3'd4
  } state_e;

  // Operands are zero-extended to ALU_W; callers keep the
  // low DATA_W bits, so ADD wraps and the carry is lost.
  function automatic logic [ALU_W-1:0] alu_op(
    input opcode_e          op,
    input logic [ALU_W-1:0] acc,
    input logic [ALU_W-1:0] rdata
  );
    logic [ALU_W-1:0] r;
    unique case (op)
      OP_ADD:  r = acc + rdata;
      OP_AND:  r = acc & rdata;
      OP_XOR:  r = acc ^ rdata;
      default: r = rdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_pc.sv
// cpu_pc: program counter register with load/increment.
// load wins over inc; increment wraps mod 2^ADDR_W.
module cpu_pc #(
  parameter int                ADDR_W   = 5,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= din;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multi-cycle accumulator CPU, req/ack memory port.
// Define CPU_RETIRE_CNT_EN to add the retire_cnt output.
module mc_cpu_core
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 5,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] acc_out,
`ifdef CPU_RETIRE_CNT_EN
  output logic [31:0]       retire_cnt,
`endif
  output logic              zero
);

  if (DATA_W < OPC_W + ADDR_W) begin : g_width_chk
    $error("mc_cpu_core: DATA_W must be >= 3 + ADDR_W");
  end

  state_e            state_q;
  state_e            state_d;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] acc_q;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] operand;
  opcode_e           opc;
  logic              xfer;
  logic              acc_zero;
  logic              pc_load;
  logic              pc_inc;
  logic              req_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic [ALU_W-1:0]  alu_wide;
  logic              unused_alu;

  assign opc      = opcode_e'(ir_q[DATA_W-1 -: OPC_W]);
  assign operand  = ir_q[ADDR_W-1:0];
  assign xfer     = mem_req & mem_ack;
  assign acc_zero = (acc_q == '0);

  assign alu_wide = alu_op(opc, ALU_W'(acc_q),
                           ALU_W'(mem_rdata));
  assign unused_alu = ^alu_wide[ALU_W-1:DATA_W];

  if (DATA_W > OPC_W + ADDR_W) begin : g_mid
    logic unused_mid;
    assign unused_mid = ^ir_q[DATA_W-OPC_W-1:ADDR_W];
  end

  cpu_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk  (clk),
    .rst  (rst),
    .load (pc_load),
    .inc  (pc_inc),
    .din  (operand),
    .pc   (pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HALT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HALT: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        if (xfer) state_d = DECODE;
      end
      DECODE: begin
        unique case (opc)
          OP_HLT:         state_d = HALT;
          OP_SKZ, OP_JMP: state_d = FETCH;
          OP_STO:         state_d = WRITE;
          default:        state_d = READ;
        endcase
      end
      READ, WRITE: begin
        if (xfer) state_d = FETCH;
      end
      default: state_d = HALT;
    endcase
  end

  // Memory outputs are precomputed from state_d so they
  // are registered and stable for the whole request.
  always_comb begin
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    unique case (state_q)
      FETCH: pc_inc = xfer;
      DECODE: begin
        pc_inc  = (opc == OP_SKZ) && acc_zero;
        pc_load = (opc == OP_JMP);
      end
      default: ;
    endcase

    pc_nxt = pc;
    unique case (1'b1)
      pc_load: pc_nxt = operand;
      pc_inc:  pc_nxt = pc + ADDR_W'(1);
      default: ;
    endcase

    req_d = 1'b0;
    if (state_d inside {FETCH, READ, WRITE}) begin
      req_d = !xfer;
    end
    we_d = (state_d == WRITE);

    addr_d = mem_addr;
    unique case (state_d)
      FETCH:       addr_d = pc_nxt;
      READ, WRITE: addr_d = operand;
      default: ;
    endcase

    wdata_d = (state_d == WRITE) ? acc_q : mem_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_q  <= '0;
      acc_q <= '0;
    end else begin
      if ((state_q == FETCH) && xfer) begin
        ir_q <= mem_rdata;
      end
      if ((state_q == READ) && xfer) begin
        acc_q <= alu_wide[DATA_W-1:0];
      end
    end
  end

`ifdef CPU_RETIRE_CNT_EN
  logic dec_ret;
  logic mem_ret;

  assign dec_ret = (state_q == DECODE) &&
                   (opc inside {OP_HLT, OP_SKZ, OP_JMP});
  assign mem_ret = ((state_q == READ) ||
                    (state_q == WRITE)) && xfer;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_cnt <= '0;
    end else if (dec_ret || mem_ret) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

  assign halted  = (state_q == HALT);
  assign pc_out  = pc;
  assign acc_out = acc_q;
  assign zero    = acc_zero;

endmodule
